// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a small first-word-fall-through FIFO between fetch and decode.
// Each entry carries a one-bit control-flow predecode flag. A flush discards all entries in one cycle.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_inst,
    input  logic [31:0]   in_pc,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc,
    output logic          out_is_ctrl,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = CW - 1;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          ctrl_mem [DEPTH];

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    logic          empty;
    logic          full;
    logic          push_en;
    logic          pop_en;
    logic          drop;
    logic          in_is_ctrl;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Pointers carry an extra wrap bit so equal indices can be told apart as empty or full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

    assign push_en = in_valid && !full && !flush;
    assign pop_en  = !empty && out_ready && !flush;
    assign drop    = in_valid && full && !flush;

    always_comb begin
        in_is_ctrl = 1'b0;
        unique case (in_inst[6:0])
            OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_SYSTEM: in_is_ctrl = 1'b1;
            default:                                   in_is_ctrl = 1'b0;
        endcase
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            inst_mem[wr_idx] <= in_inst;
            pc_mem[wr_idx]   <= in_pc;
            ctrl_mem[wr_idx] <= in_is_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Fetch cannot stall, so a dropped push is latched until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = wr_ptr - rd_ptr;

    always_comb begin
        out_inst    = '0;
        out_pc      = '0;
        out_is_ctrl = 1'b0;
        if (!empty) begin
            out_inst    = inst_mem[rd_idx];
            out_pc      = pc_mem[rd_idx];
            out_is_ctrl = ctrl_mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue: reset, fill/overflow, predecode, wrap, flush, async reset.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_ctrl;
    logic [2:0]  count;
    logic        overflow;

    int check_count = 0;
    int pass_count  = 0;

    inst_fetch_queue #(.DEPTH(4), .CW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_is_ctrl (out_is_ctrl),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle with the given inputs; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    logic [31:0] pred_insts [5];
    logic        pred_exp   [5];

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready",  in_ready,  1);
        checkOutput("reset_count",     count,     0);
        checkOutput("reset_overflow",  overflow,  0);
        checkOutput("reset_out_inst",  out_inst,  0);

        applyStimulus(1, 32'h00000413, 32'h80000000, 0, 0);
        checkOutput("first_out_valid", out_valid,   1);
        checkOutput("first_out_inst",  out_inst,    32'h00000413);
        checkOutput("first_out_pc",    out_pc,      32'h80000000);
        checkOutput("first_is_ctrl",   out_is_ctrl, 0);
        checkOutput("first_count",     count,       1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("first_pop_count", count, 0);

        // Fill to capacity, then one push too many.
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h00000013, 32'h80000000 + 4 * i, 0, 0);
        checkOutput("full_count",    count,    4);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_overflow", overflow, 0);
        applyStimulus(1, 32'h00000013, 32'h80000010, 0, 0);
        checkOutput("drop_overflow", overflow, 1);
        checkOutput("drop_count",    count,    4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_pc%0d", i), out_pc, 32'h80000000 + 4 * i);
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("drain_out_valid", out_valid, 0);
        checkOutput("drain_out_pc",    out_pc,    0);
        checkOutput("sticky_overflow", overflow,  1);

        pred_insts[0] = 32'h0000006F; pred_exp[0] = 1'b1;
        pred_insts[1] = 32'h00008067; pred_exp[1] = 1'b1;
        pred_insts[2] = 32'h00000063; pred_exp[2] = 1'b1;
        pred_insts[3] = 32'h00000073; pred_exp[3] = 1'b1;
        pred_insts[4] = 32'h00000013; pred_exp[4] = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1, pred_insts[i], 32'h80000020 + 4 * i, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("predecode%0d", i), out_is_ctrl, pred_exp[i]);
            applyStimulus(0, 0, 0, 1, 0);
        end
        applyStimulus(1, pred_insts[4], 32'h80000030, 0, 0);
        checkOutput("predecode4", out_is_ctrl, pred_exp[4]);
        applyStimulus(0, 0, 0, 1, 0);

        // Steady push+pop at count 2 walks both pointers through several wraps.
        applyStimulus(1, 32'h00000013, 32'h80000040, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h80000044, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("wrap_head%0d", i), out_pc, 32'h80000040 + 4 * i);
            applyStimulus(1, 32'h00000013, 32'h80000048 + 4 * i, 1, 0);
            checkOutput($sformatf("wrap_count%0d", i), count, 2);
        end
        checkOutput("wrap_tail0", out_pc, 32'h80000068);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("wrap_tail1", out_pc, 32'h8000006C);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("wrap_empty", out_valid, 0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h00000013, 32'h80000080 + 4 * i, 0, 0);
        checkOutput("preflush_count", count, 3);
        applyStimulus(1, 32'h00000013, 32'h8000008C, 1, 1);
        checkOutput("flush_count",     count,     0);
        checkOutput("flush_out_valid", out_valid, 0);
        applyStimulus(1, 32'h00000013, 32'h80000100, 0, 0);
        checkOutput("postflush_pc",    out_pc, 32'h80000100);
        checkOutput("postflush_count", count,  1);
        applyStimulus(0, 0, 0, 1, 0);

        // Asynchronous reset between edges must clear the queue immediately.
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h00000013, 32'h80000200 + 4 * i, 0, 0);
        checkOutput("prereset_count", count, 3);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_out_valid", out_valid, 0);
        checkOutput("async_count",     count,     0);
        checkOutput("async_overflow",  overflow,  0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Flush concurrent with a push into a full queue must not flag overflow.
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h00000013, 32'h80000300 + 4 * i, 0, 0);
        checkOutput("full2_count", count, 4);
        applyStimulus(1, 32'h00000013, 32'h80000310, 0, 1);
        checkOutput("flushfull_overflow", overflow, 0);
        checkOutput("flushfull_count",    count,    0);
        checkOutput("flushfull_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Small FIFO between the instruction-fetch stage and the decode stage.
- Decouples fetch (which cannot stall) from decode (which applies backpressure via valid/ready).
- Attaches a one-bit control-flow predecode flag to each entry.
- Supports a single-cycle flush on pipeline redirect.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- CW, 3: count width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  fetch stage presents a valid instruction this cycle.
- in_inst  in  32  fetched instruction word.
- in_pc  in  32  PC of in_inst.
- in_ready  out  1  queue can accept; equals !full.
- flush  in  1  redirect; discard all entries.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  decode consumes head this cycle.
- out_inst  out  32  head instruction; 0 when out_valid=0.
- out_pc  out  32  head PC; 0 when out_valid=0.
- out_is_ctrl  out  1  head is control flow; 0 when out_valid=0.
- count  out  CW  number of occupied entries, 0..DEPTH.
- overflow  out  1  sticky: a valid push was dropped because the queue was full.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {inst[31:0], pc[31:0], is_ctrl}.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits with a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = index bits equal and wrap bits differ.
- count = wr_ptr - rd_ptr, modulo 2^CW.
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, overflow=0.
  - Outputs during reset: out_valid=0, in_ready=1, count=0, out_inst=0, out_pc=0, out_is_ctrl=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Push: at the edge, when in_valid=1, !full and flush=0.
  - Write the entry at wr_ptr.
  - wr_ptr += 1 (wraps naturally).
- Predecode, computed on in_inst at push: is_ctrl = 1 iff in_inst[6:0] is one of
  - 1101111 (JAL)
  - 1100111 (JALR)
  - 1100011 (BRANCH)
  - 1110011 (SYSTEM)
- Pop: at the edge, when out_valid=1, out_ready=1 and flush=0. Then rd_ptr += 1.
- out_ready while empty: no effect.
- Head outputs: first-word fall-through.
  - out_inst, out_pc and out_is_ctrl are driven combinationally from the entry at rd_ptr.
- Latency: an entry pushed at edge N appears on the outputs after edge N. No same-cycle bypass when empty.
- Simultaneous push and pop when neither full nor empty: both occur; count unchanged.
- Push while full: in_ready=0.
  - The push is dropped even if a pop occurs the same cycle.
  - overflow is set to 1.
  - Fetch does not stall, so a drop is a recorded error.
- overflow is cleared only by reset.
- Flush (flush=1 at the edge): highest priority.
  - rd_ptr <= wr_ptr, so the queue becomes empty.
  - Any concurrent push and pop are ignored.
  - A concurrent push-while-full does not set overflow.
- Pointer wrap: indices wrap at DEPTH; the wrap bit toggles. Full/empty stay correct across any number of wraps.

Test Plan:
- Reset ordering: hold rst=0 for 3 cycles, then release -> out_valid=0, in_ready=1, count=0, overflow=0, out_inst=0. Then push {inst=32'h00000413, pc=32'h80000000} -> next cycle out_valid=1, out_inst=32'h00000413, out_pc=32'h80000000, out_is_ctrl=0, count=1.
- Fill and overflow: with out_ready=0, push 5 entries (pc 80000000..80000010).
  - After 4 pushes: count=4, in_ready=0.
  - 5th push is dropped: overflow=1, count stays 4.
  - Drain with out_ready=1 -> pcs 80000000, 80000004, 80000008, 8000000C in order, then out_valid=0.
- Predecode: push 32'h0000006F, 32'h00008067, 32'h00000063, 32'h00000073 and 32'h00000013 -> out_is_ctrl reads 1,1,1,1,0 on successive pops.
- Simultaneous push/pop and wrap: keep count=2 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, PCs exit in push order with no loss across pointer wraps.
- Flush: with count=3, assert flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The next push, pc=80000100, is the next popped entry.
- Async reset mid-operation: with count=3, drop rst between clock edges -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
